// File: rtl/axi_reg_bridge.sv
// AXI3 slave front-end for the GP1 port: turns AXI bursts into a simple
// one-word-per-beat register bus with independent read and write engines.
module axi_reg_bridge #(
  parameter int REG_ADDR_W = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [31:0]           ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [11:0]           ARID,
  input  logic [3:0]            ARLEN,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARSIZE,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic [3:0]            ARQOS,
  output logic [31:0]           RDATA,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [11:0]           RID,
  output logic                  RLAST,
  output logic [1:0]            RRESP,
  input  logic [31:0]           AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [11:0]           AWID,
  input  logic [3:0]            AWLEN,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWSIZE,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic [3:0]            AWQOS,
  input  logic [31:0]           WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [11:0]           WID,
  input  logic                  WLAST,
  input  logic [3:0]            WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [11:0]           BID,
  output logic [1:0]            BRESP,
  output logic [REG_ADDR_W-1:0] reg_waddr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  output logic                  reg_wen,
  output logic [REG_ADDR_W-1:0] reg_raddr,
  output logic                  reg_ren,
  input  logic [31:0]           reg_rdata
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_DATA
  } r_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  logic unused;
  assign unused = ^{ARSIZE, ARLOCK, ARCACHE, ARPROT, ARQOS,
                    AWSIZE, AWLOCK, AWCACHE, AWPROT, AWQOS,
                    ARADDR[31:REG_ADDR_W+2], ARADDR[1:0],
                    AWADDR[31:REG_ADDR_W+2], AWADDR[1:0]};

  // Holds both address channels off until the first edge after reset.
  logic alive;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  w_state_t              w_state;
  w_state_t              w_next;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [11:0]           w_id;
  logic [3:0]            w_len;
  logic [1:0]            w_burst;
  logic [3:0]            w_cnt;
  logic                  w_err;
  logic                  w_last;
  logic                  w_bad;
  logic                  w_beat;

  assign w_last = (w_cnt == w_len);
  assign w_bad  = w_burst[1];
  assign w_beat = WVALID && WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = RESP_OKAY;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = alive;
        if (AWVALID && alive) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BID    = w_id;
        BRESP  = w_err ? RESP_SLV : RESP_OKAY;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_addr    <= '0;
      w_id      <= '0;
      w_len     <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      reg_wen   <= 1'b0;
    end else begin
      reg_wen <= 1'b0;
      if (AWVALID && AWREADY) begin
        w_addr  <= AWADDR[REG_ADDR_W+1:2];
        w_id    <= AWID;
        w_len   <= AWLEN;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= AWBURST[1];
      end
      if (w_beat) begin
        reg_waddr <= w_addr;
        reg_wdata <= WDATA;
        reg_wstrb <= WSTRB;
        reg_wen   <= (|WSTRB) && !w_bad;
        // ID mismatch still writes; WLAST off the counted last beat flags too.
        if ((WID != w_id) || (WLAST != w_last)) w_err <= 1'b1;
        w_cnt <= w_cnt + 4'd1;
        if (w_burst == BURST_INCR) w_addr <= w_addr + REG_ADDR_W'(1);
      end
    end
  end

  r_state_t              r_state;
  r_state_t              r_next;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [11:0]           r_id;
  logic [3:0]            r_len;
  logic [1:0]            r_burst;
  logic [3:0]            r_cnt;
  logic [31:0]           r_data;
  logic                  r_last;
  logic                  r_bad;

  assign r_last    = (r_cnt == r_len);
  assign r_bad     = r_burst[1];
  assign reg_raddr = r_addr;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    reg_ren = 1'b0;
    RVALID  = 1'b0;
    RDATA   = '0;
    RID     = '0;
    RLAST   = 1'b0;
    RRESP   = RESP_OKAY;
    unique case (r_state)
      R_IDLE: begin
        ARREADY = alive;
        if (ARVALID && alive) r_next = R_REQ;
      end
      R_REQ: begin
        reg_ren = !r_bad;
        r_next  = R_WAIT;
      end
      R_WAIT: r_next = R_DATA;
      R_DATA: begin
        RVALID = 1'b1;
        RDATA  = r_data;
        RID    = r_id;
        RLAST  = r_last;
        RRESP  = r_bad ? RESP_SLV : RESP_OKAY;
        if (RREADY) r_next = r_last ? R_IDLE : R_REQ;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      if (ARVALID && ARREADY) begin
        r_addr  <= ARADDR[REG_ADDR_W+1:2];
        r_id    <= ARID;
        r_len   <= ARLEN;
        r_burst <= ARBURST;
        r_cnt   <= '0;
      end
      if (r_state == R_WAIT) r_data <= r_bad ? '0 : reg_rdata;
      if ((r_state == R_DATA) && RREADY && !r_last) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_burst == BURST_INCR) r_addr <= r_addr + REG_ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Directed bench for axi_reg_bridge: vector tables for read and write
// bursts plus hand sequences for stalls, overlap and mid-burst reset.
module tb_axi_reg_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [11:0] ARID = '0;
  logic [3:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [11:0] RID;
  logic        RLAST;
  logic [1:0]  RRESP;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [11:0] AWID = '0;
  logic [3:0]  AWLEN = '0;
  logic [1:0]  AWBURST = '0;
  logic [31:0] WDATA = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [11:0] WID = '0;
  logic        WLAST = 1'b0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [11:0] BID;
  logic [1:0]  BRESP;
  logic [7:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_wen;
  logic [7:0]  reg_raddr;
  logic        reg_ren;
  logic [31:0] reg_rdata = '0;

  always #5 ACLK = ~ACLK;

  axi_reg_bridge #(.REG_ADDR_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARSIZE(2'b10), .ARLOCK(2'b00), .ARCACHE(4'h0),
    .ARPROT(3'h0), .ARQOS(4'h0),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .RID(RID), .RLAST(RLAST), .RRESP(RRESP),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWID(AWID), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWSIZE(2'b10), .AWLOCK(2'b00), .AWCACHE(4'h0),
    .AWPROT(3'h0), .AWQOS(4'h0),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .WID(WID), .WLAST(WLAST), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_wen(reg_wen),
    .reg_raddr(reg_raddr), .reg_ren(reg_ren), .reg_rdata(reg_rdata)
  );

  // Register file: unwritten words read as 0x100 + word address.
  logic [31:0]  mem [256];
  logic [255:0] written = '0;
  int           wen_cnt = 0;
  int           ren_cnt = 0;
  int           both_cnt = 0;
  logic [7:0]   last_waddr = '0;
  logic [31:0]  last_wdata = '0;
  logic [3:0]   last_wstrb = '0;

  function automatic logic [31:0] rf_rd(input logic [7:0] a);
    return written[a] ? mem[a] : 32'h100 + {24'h0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge ACLK) begin
    if (reg_ren) begin
      reg_rdata <= rf_rd(reg_raddr);
      ren_cnt   <= ren_cnt + 1;
    end
    if (reg_wen) begin
      mem[reg_waddr]     <= merge(rf_rd(reg_waddr), reg_wdata, reg_wstrb);
      written[reg_waddr] <= 1'b1;
      wen_cnt            <= wen_cnt + 1;
      last_waddr         <= reg_waddr;
      last_wdata         <= reg_wdata;
      last_wstrb         <= reg_wstrb;
    end
    if (reg_wen && reg_ren) both_cnt <= both_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [11:0] id;
    logic [11:0] wid;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          wlast_at;
    logic [3:0]  strb;
    logic [31:0] data;
    int          exp_wen;
    logic [1:0]  exp_bresp;
    logic [7:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } wvec_t;

  typedef struct {
    logic [31:0] addr;
    logic [11:0] id;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [7:0]  base;
    logic [7:0]  step;
    logic        bad;
  } rvec_t;

  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [11:0] rd_id [16];
  logic [1:0]  rd_resp [16];

  task automatic ar_send(input logic [31:0] a, input logic [11:0] id,
                         input logic [3:0] len, input logic [1:0] burst);
    int t;
    @(negedge ACLK);
    ARADDR = a; ARID = id; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    chk("ar_ready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic r_beat(input int i);
    int t;
    RREADY = 1'b1;
    t = 0;
    while (!RVALID && t < 100) begin @(negedge ACLK); t++; end
    chk($sformatf("r_valid_%0d", i), RVALID, 1);
    rd_data[i] = RDATA; rd_last[i] = RLAST;
    rd_id[i] = RID; rd_resp[i] = RRESP;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic do_write(input wvec_t v, output logic [1:0] bresp,
                          output logic [11:0] bid);
    int t;
    @(negedge ACLK);
    AWADDR = v.addr; AWID = v.id; AWLEN = v.len;
    AWBURST = v.burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
    chk("aw_ready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      WVALID = 1'b1; WDATA = v.data + b; WSTRB = v.strb;
      WID = v.wid; WLAST = (b == v.wlast_at);
      t = 0;
      while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
      chk("w_ready", WREADY, 1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    chk("b_valid", BVALID, 1);
    bresp = BRESP; bid = BID;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  wvec_t wv [10];
  rvec_t rv [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  bresp, rresp;
    logic [11:0] bid;
    logic [31:0] rdata;
    logic [7:0]  w;
    logic        got_b, got_r;
    int          c0, t;

    wv[0] = '{32'h4, 12'h0, 12'h0, 4'd0, 2'b01, 0, 4'b1011,
              32'hdeadbeef, 1, 2'b00, 8'h01, 32'hdeadbeef};
    wv[1] = '{32'h20, 12'h3, 12'h3, 4'd1, 2'b10, 1, 4'hf,
              32'h5000, 0, 2'b10, 8'h00, 32'h0};
    wv[2] = '{32'h30, 12'h7, 12'h8, 4'd0, 2'b01, 0, 4'hf,
              32'h11111111, 1, 2'b10, 8'h0c, 32'h11111111};
    wv[3] = '{32'h40, 12'h2, 12'h2, 4'd2, 2'b01, 1, 4'hf,
              32'h100, 3, 2'b10, 8'h12, 32'h102};
    wv[4] = '{32'h50, 12'habc, 12'habc, 4'd3, 2'b01, 3, 4'b0011,
              32'ha0, 4, 2'b00, 8'h17, 32'ha3};
    wv[5] = '{32'h60, 12'h1, 12'h1, 4'd2, 2'b00, 2, 4'hf,
              32'h200, 3, 2'b00, 8'h18, 32'h202};
    wv[6] = '{32'h70, 12'h4, 12'h4, 4'd0, 2'b01, 0, 4'h0,
              32'h77, 0, 2'b00, 8'h00, 32'h0};
    wv[7] = '{32'hf00003fc, 12'h5, 12'h5, 4'd1, 2'b01, 1, 4'hf,
              32'h300, 2, 2'b00, 8'h00, 32'h301};
    wv[8] = '{32'h80, 12'h6, 12'h6, 4'd0, 2'b11, 0, 4'hf,
              32'h400, 0, 2'b10, 8'h00, 32'h0};
    wv[9] = '{32'h84, 12'h9, 12'h9, 4'd1, 2'b01, 5, 4'hf,
              32'h500, 2, 2'b10, 8'h22, 32'h501};

    rv[0] = '{32'h10, 12'h05a, 4'd3, 2'b01, 8'h04, 8'd1, 1'b0};
    rv[1] = '{32'h80, 12'h123, 4'd2, 2'b00, 8'h20, 8'd0, 1'b0};
    rv[2] = '{32'h90, 12'h007, 4'd1, 2'b10, 8'h00, 8'd0, 1'b1};
    rv[3] = '{32'hab0003f8, 12'h000, 4'd2, 2'b01, 8'hfe, 8'd1, 1'b0};
    rv[4] = '{32'h3c, 12'hfff, 4'd0, 2'b01, 8'h0f, 8'd0, 1'b0};
    rv[5] = '{32'h40, 12'h001, 4'd0, 2'b11, 8'h00, 8'd0, 1'b1};

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_reg_ren", reg_ren, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_awready", AWREADY, 1);
    chk("idle_arready", ARREADY, 1);

    // Read vector table
    foreach (rv[i]) begin
      c0 = ren_cnt;
      ar_send(rv[i].addr, rv[i].id, rv[i].len, rv[i].burst);
      for (int b = 0; b <= int'(rv[i].len); b++) r_beat(b);
      for (int b = 0; b <= int'(rv[i].len); b++) begin
        w = rv[i].base + 8'(b) * rv[i].step;
        chk($sformatf("r%0d_b%0d_data", i, b), rd_data[b],
            rv[i].bad ? 32'h0 : 32'h100 + {24'h0, w});
        chk($sformatf("r%0d_b%0d_last", i, b), rd_last[b],
            b == int'(rv[i].len));
        chk($sformatf("r%0d_b%0d_id", i, b), rd_id[b], rv[i].id);
        chk($sformatf("r%0d_b%0d_resp", i, b), rd_resp[b],
            rv[i].bad ? 2'b10 : 2'b00);
      end
      chk($sformatf("r%0d_ren_cnt", i), ren_cnt - c0,
          rv[i].bad ? 0 : int'(rv[i].len) + 1);
    end

    // RREADY stall on beat 2 of a 3-beat read
    c0 = ren_cnt;
    ar_send(32'h100, 12'h0aa, 4'd2, 2'b01);
    r_beat(0);
    t = 0;
    while (!RVALID && t < 100) begin @(negedge ACLK); t++; end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_valid_%0d", k), RVALID, 1);
      chk($sformatf("stall_data_%0d", k), RDATA, 32'h141);
      chk($sformatf("stall_last_%0d", k), RLAST, 0);
      chk($sformatf("stall_id_%0d", k), RID, 12'h0aa);
      @(negedge ACLK);
    end
    chk("stall_ren_cnt", ren_cnt - c0, 2);
    r_beat(1);
    r_beat(2);
    chk("stall_b0", rd_data[0], 32'h140);
    chk("stall_b1", rd_data[1], 32'h141);
    chk("stall_b2", rd_data[2], 32'h142);
    chk("stall_last2", rd_last[2], 1);
    chk("stall_ren_total", ren_cnt - c0, 3);

    // Write vector table
    foreach (wv[i]) begin
      c0 = wen_cnt;
      do_write(wv[i], bresp, bid);
      chk($sformatf("w%0d_bresp", i), bresp, wv[i].exp_bresp);
      chk($sformatf("w%0d_bid", i), bid, wv[i].id);
      chk($sformatf("w%0d_wen_cnt", i), wen_cnt - c0, wv[i].exp_wen);
      if (wv[i].exp_wen > 0) begin
        chk($sformatf("w%0d_waddr", i), last_waddr, wv[i].exp_waddr);
        chk($sformatf("w%0d_wdata", i), last_wdata, wv[i].exp_wdata);
        chk($sformatf("w%0d_wstrb", i), last_wstrb, wv[i].strb);
      end
    end

    // Read-back of the partial-strobe write and an early-WLAST burst
    ar_send(32'h4, 12'h1, 4'd0, 2'b01);
    r_beat(0);
    chk("rb_strb_1011", rd_data[0], 32'hde00beef);
    ar_send(32'h44, 12'h1, 4'd1, 2'b01);
    r_beat(0);
    r_beat(1);
    chk("rb_early_b1", rd_data[0], 32'h101);
    chk("rb_early_b2", rd_data[1], 32'h102);

    // Overlapping single-beat write and read to 0x8
    c0 = both_cnt;
    @(negedge ACLK);
    AWADDR = 32'h8; AWID = 12'h9; AWLEN = 4'd0; AWBURST = 2'b01;
    AWVALID = 1'b1;
    WVALID = 1'b1; WDATA = 32'hcafef00d; WSTRB = 4'hf;
    WID = 12'h9; WLAST = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    ARADDR = 32'h8; ARID = 12'h033; ARLEN = 4'd0; ARBURST = 2'b01;
    ARVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    got_b = 1'b0; got_r = 1'b0;
    bresp = 2'b11; rresp = 2'b11; rdata = '0;
    t = 0;
    while (!(got_b && got_r) && t < 100) begin
      if (BVALID && !got_b) begin got_b = 1'b1; bresp = BRESP; end
      if (RVALID && !got_r) begin got_r = 1'b1; rdata = RDATA; rresp = RRESP; end
      @(negedge ACLK);
      t++;
    end
    BREADY = 1'b0; RREADY = 1'b0;
    chk("ovl_got_b", got_b, 1);
    chk("ovl_got_r", got_r, 1);
    chk("ovl_same_cycle", both_cnt - c0, 1);
    chk("ovl_old_data", rdata, 32'h102);
    chk("ovl_rresp", rresp, 2'b00);
    chk("ovl_bresp", bresp, 2'b00);
    ar_send(32'h8, 12'h034, 4'd0, 2'b01);
    r_beat(0);
    chk("ovl_new_data", rd_data[0], 32'hcafef00d);

    // Reset during beat 2 of a 4-beat read
    ar_send(32'h20, 12'h044, 4'd3, 2'b01);
    r_beat(0);
    t = 0;
    while (!RVALID && t < 100) begin @(negedge ACLK); t++; end
    chk("mid_rdata", RDATA, 32'h109);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_arready", ARREADY, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_rvalid", RVALID, 0);
    chk("post_rst_bvalid", BVALID, 0);
    ar_send(32'h24, 12'h055, 4'd0, 2'b01);
    r_beat(0);
    chk("post_rst_data", rd_data[0], 32'h109);
    chk("post_rst_last", rd_last[0], 1);
    chk("post_rst_id", rd_id[0], 12'h055);
    chk("post_rst_resp", rd_resp[0], 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
